idt7201_reader: RTL

Synchronous read-side controller for an external IDT7201A 512x9 asynchronous FIFO. Generates the FIFO's active-low read and reset strobes with cycle-counted pulse widths, synchronises the asynchronous EF_ flag, captures each word from the FIFO's Q bus and presents it on a one-entry valid/ready output stream. It sits between the FIFO's read port and on-board synchronous logic. The FIFO's write side is driven by an independent, unrelated clock domain.

---
 rtl/idt7201_pkg.sv | 22 ++
 rtl/idt7201_reader_sync_2ff.sv | 30 +++
 rtl/idt7201_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/idt7201_pkg.sv
// Shared definitions for the IDT7201A read-side controller.
// Contents:
//   state_t     - controller FSM states
//   WORD_W      - width of one FIFO word (8 data bits + 1 flag bit)
//   SYNC_STAGES - flop depth of the EF_ synchroniser
//   COUNT_W     - width of the captured-word counter
//   CNT_W       - width of the shared pulse-width down-counter
package idt7201_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int WORD_W      = 9;
    localparam int SYNC_STAGES = 2;
    localparam int COUNT_W     = 16;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/idt7201_reader_sync_2ff.sv
// Double-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk   - destination clock
//   reset - synchronous, active-high; clears both flops
//   d     - asynchronous input
//   q     - synchronised output, SYNC_STAGES cycles of latency
module sync_2ff
    import idt7201_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw input through the chain; only the last flop is observed,
    // giving the first flop a full cycle to resolve metastability.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/idt7201_reader.sv
// Read-side controller for an external IDT7201A 512x9 asynchronous FIFO.
// Resets the FIFO, issues cycle-counted read strobes while the (synchronised)
// empty flag says data is present, captures each word and offers it on a
// one-entry valid/ready stream.
// Ports:
//   CLK, RESET        - system clock, synchronous active-high reset
//   FLUSH             - reset the external FIFO and drop buffered output
//   FIFO_EF_, FIFO_Q  - FIFO empty flag (async, active-low) and data bus
//   FIFO_R_, FIFO_RS_ - FIFO read and reset strobes (active-low, registered)
//   DOUT, DOUT_VALID, DOUT_READY - output word stream
//   BUSY              - FIFO reset in progress
//   WORD_COUNT        - words captured since last reset/flush (wraps)
module idt7201_reader
    import idt7201_pkg::*;
#(
    parameter int READ_LOW_CYCLES  = 3,
    parameter int READ_HIGH_CYCLES = 3,
    parameter int RESET_CYCLES     = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               FLUSH,
    input  logic               FIFO_EF_,
    input  logic [WORD_W-1:0]  FIFO_Q,
    output logic               FIFO_R_,
    output logic               FIFO_RS_,
    output logic [WORD_W-1:0]  DOUT,
    output logic               DOUT_VALID,
    input  logic               DOUT_READY,
    output logic               BUSY,
    output logic [COUNT_W-1:0] WORD_COUNT
);

    localparam logic [CNT_W-1:0] LOW_LOAD   = CNT_W'(READ_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(READ_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             flush_pend;
    logic             flush_pend_next;
    logic             ef_s;
    logic             slot_free;
    logic             start_read;
    logic             capture;
    logic             init_entry;

    sync_2ff u_ef_sync (
        .clk   (CLK),
        .reset (RESET),
        .d     (FIFO_EF_),
        .q     (ef_s)
    );

    assign slot_free  = !DOUT_VALID || DOUT_READY;
    assign start_read = ef_s && slot_free;

    // Next-state logic. The single down-counter is loaded on entry to STROBE
    // and HOLD and the state is left on the cycle it reads zero. INIT is
    // entered with the counter cleared, so its first cycle loads the count
    // and it is left when the count reaches one; this keeps the reset pulse
    // exactly RESET_CYCLES long whether INIT was entered by RESET or FLUSH.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        flush_pend_next = flush_pend;
        capture         = 1'b0;
        init_entry      = 1'b0;

        case (state)
            INIT: begin
                if (FLUSH) begin
                    init_entry = 1'b1;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    cnt_next = RESET_LOAD;
                end else if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            IDLE: begin
                if (FLUSH) begin
                    state_next = INIT;
                    init_entry = 1'b1;
                    cnt_next   = '0;
                end else if (start_read) begin
                    state_next = STROBE;
                    cnt_next   = LOW_LOAD;
                end
            end

            // A flush arriving mid-strobe is remembered so the read can finish
            // cleanly; the FIFO is then reset straight from the capture edge.
            STROBE: begin
                if (FLUSH) begin
                    flush_pend_next = 1'b1;
                end
                if (cnt == '0) begin
                    capture = 1'b1;
                    if (FLUSH || flush_pend) begin
                        state_next = INIT;
                        init_entry = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        state_next = HOLD;
                        cnt_next   = HIGH_LOAD;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            HOLD: begin
                if (FLUSH) begin
                    state_next = INIT;
                    init_entry = 1'b1;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    if (start_read) begin
                        state_next = STROBE;
                        cnt_next   = LOW_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_next = INIT;
                init_entry = 1'b1;
                cnt_next   = '0;
            end
        endcase

        if (init_entry) begin
            flush_pend_next = 1'b0;
        end
    end

    // State register and registered outputs. Strobes and BUSY are decoded
    // from the next state so they change on the same edge as the state.
    // On INIT entry the stream is emptied even if a word is captured on the
    // same edge; otherwise a capture wins over a simultaneous accept.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= INIT;
            cnt        <= '0;
            flush_pend <= 1'b0;
            FIFO_R_    <= 1'b1;
            FIFO_RS_   <= 1'b0;
            BUSY       <= 1'b1;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            WORD_COUNT <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            flush_pend <= flush_pend_next;
            FIFO_R_    <= (state_next != STROBE);
            FIFO_RS_   <= (state_next != INIT);
            BUSY       <= (state_next == INIT);

            if (capture) begin
                DOUT <= FIFO_Q;
            end

            if (init_entry) begin
                DOUT_VALID <= 1'b0;
                WORD_COUNT <= '0;
            end else if (capture) begin
                DOUT_VALID <= 1'b1;
                WORD_COUNT <= WORD_COUNT + COUNT_W'(1);
            end else if (DOUT_VALID && DOUT_READY) begin
                DOUT_VALID <= 1'b0;
            end
        end
    end

endmodule
